// File: rtl/counter_ctrl.sv
// Push-button front end for the 4-bit universal counter.
// It synchronises and debounces four raw buttons and turns presses into
// toggles and strobes. A programmable tick divider paces the count steps.
module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_clear,
  input  logic btn_mode,
  input  logic btn_dir,
  input  logic btn_pause,
  output logic clear,
  output logic mode,
  output logic incr,
  output logic pause,
  output logic running
);

  localparam int unsigned NB      = 4;
  localparam int unsigned CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned B_CLEAR = 0;
  localparam int unsigned B_MODE  = 1;
  localparam int unsigned B_DIR   = 2;
  localparam int unsigned B_PAUSE = 3;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;
  logic [NB-1:0] stable_d;
  logic [NB-1:0] press_c;
  logic [CW-1:0] db_cnt [NB];
  logic [DW-1:0] div;
  logic          div_last_c;
  logic          step_c;

  assign raw = {btn_pause, btn_dir, btn_mode, btn_clear};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: a new level is accepted after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A press is a rising edge of the debounced level; releases are ignored
  assign press_c = stable & ~stable_d;

  // The step is due on the last divider count of each running period
  assign div_last_c = (div == DW'(TICK_DIV - 1));
  assign step_c     = running & div_last_c;

  // Tick divider: it advances only while running, and a clear press restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (press_c[B_CLEAR]) begin
      div <= '0;
    end else if (running) begin
      div <= div_last_c ? '0 : div + DW'(1);
    end
  end

  // Registered counter controls. A clear press drops any step that is due in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear   <= 1'b0;
      mode    <= 1'b1;
      incr    <= 1'b1;
      pause   <= 1'b1;
      running <= 1'b0;
    end else begin
      clear <= press_c[B_CLEAR];
      pause <= ~(step_c & ~press_c[B_CLEAR]);
      if (press_c[B_MODE])  mode    <= ~mode;
      if (press_c[B_DIR])   incr    <= ~incr;
      if (press_c[B_PAUSE]) running <= ~running;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with DEBOUNCE_CYCLES=4 and TICK_DIV=8.
// Expected step edges are queued when stimulus is applied. They are popped when the DUT drops pause.
module tb_counter_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned T = 8;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic btn_clear = 1'b0;
  logic btn_mode  = 1'b0;
  logic btn_dir   = 1'b0;
  logic btn_pause = 1'b0;
  logic clear;
  logic mode;
  logic incr;
  logic pause;
  logic running;

  int tests   = 0;
  int fails   = 0;
  int edge_no = 0;
  int step_q[$];

  logic [3:0] model   = 4'd0;
  logic       clr_q   = 1'b0;
  logic       pause_q = 1'b1;
  logic       mode_q  = 1'b1;
  logic       incr_q  = 1'b1;

  counter_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_clear(btn_clear),
    .btn_mode (btn_mode),
    .btn_dir  (btn_dir),
    .btn_pause(btn_pause),
    .clear    (clear),
    .mode     (mode),
    .incr     (incr),
    .pause    (pause),
    .running  (running)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge=%0d", edge_no);
    $fatal(1);
  end

  // Reference 4-bit universal counter: hex or decimal, up or down
  function automatic logic [3:0] next_count(input logic [3:0] c, input logic hex, input logic up);
    if (up) return (!hex && c >= 4'd9) ? 4'd0 : c + 4'd1;
    return (c == 4'd0) ? (hex ? 4'hF : 4'd9) : c - 4'd1;
  endfunction

  // Advance one edge, sample 1ns later, update the counter model and check steps against the scoreboard
  task automatic tick();
    int exp_e;
    @(posedge clk);
    #1;
    edge_no++;
    if (clr_q) model = 4'd0;
    else if (!pause_q) model = next_count(model, mode_q, incr_q);
    if (pause === 1'b0) begin
      tests++;
      if (step_q.size() == 0) begin
        fails++;
        $display("FAIL step_unexpected: pause low at edge %0d, no step expected", edge_no);
      end else begin
        exp_e = step_q.pop_front();
        if (edge_no !== exp_e) begin
          fails++;
          $display("FAIL step_edge: got step at edge %0d, expected edge %0d", edge_no, exp_e);
        end
      end
    end
    clr_q   = clear;
    pause_q = pause;
    mode_q  = mode;
    incr_q  = incr;
  endtask

  task automatic run_to(input int target);
    while (edge_no < target) tick();
  endtask

  task automatic push_steps(input int first, input int last);
    for (int e = first; e <= last; e += T) step_q.push_back(e);
  endtask

  // Apply reset and release it. Edge 0 is the first posedge after release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_clear = 1'b0; btn_mode = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    edge_no = 0;
    step_q.delete();
    model = 4'd0; clr_q = 1'b0; pause_q = 1'b1; mode_q = 1'b1; incr_q = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({clear, mode, incr, pause, running} !== 5'b01110) begin
      fails++;
      $display("FAIL reset_hold: outputs=%b expected=01110", {clear, mode, incr, pause, running});
    end
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      tests++;
      if ({clear, mode, incr, pause, running} !== 5'b01110) begin
        fails++;
        $display("FAIL reset_idle edge %0d: outputs=%b expected=01110", edge_no, {clear, mode, incr, pause, running});
      end
    end
  endtask

  task automatic test_run();
    do_reset();
    btn_pause = 1'b1;
    push_steps(15, 55);
    run_to(6);
    tests++;
    if (running !== 1'b0) begin fails++; $display("FAIL run_early: running=%b expected 0 at edge 6", running); end
    run_to(7);
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL run_start: running=%b expected 1 at edge 7", running); end
    run_to(10);
    btn_pause = 1'b0;
    run_to(56);
    tests++;
    if (model !== 4'd6 || running !== 1'b1) begin
      fails++;
      $display("FAIL run_count: count=%h running=%b expected count=6 running=1", model, running);
    end
    tests++;
    if (step_q.size() != 0) begin fails++; $display("FAIL run_drain: %0d steps missing, expected 0", step_q.size()); end
  endtask

  task automatic test_mode_glitch();
    do_reset();
    btn_mode = 1'b1;
    run_to(3);
    btn_mode = 1'b0;
    run_to(15);
    tests++;
    if (mode !== 1'b1) begin fails++; $display("FAIL mode_glitch: mode=%b expected 1", mode); end
    btn_mode = 1'b1;
    run_to(21);
    tests++;
    if (mode !== 1'b1) begin fails++; $display("FAIL mode_early: mode=%b expected 1 at edge 21", mode); end
    run_to(22);
    tests++;
    if (mode !== 1'b0) begin fails++; $display("FAIL mode_toggle: mode=%b expected 0 at edge 22", mode); end
    run_to(25);
    btn_mode = 1'b0;
    run_to(40);
    tests++;
    if (mode !== 1'b0) begin fails++; $display("FAIL mode_release: mode=%b expected 0", mode); end
    btn_pause = 1'b1;
    push_steps(55, 143);
    run_to(50);
    btn_pause = 1'b0;
    run_to(128);
    tests++;
    if (model !== 4'd0) begin fails++; $display("FAIL dec_wrap: count=%h expected 0 after 10 steps", model); end
    run_to(144);
    tests++;
    if (model !== 4'd2) begin fails++; $display("FAIL dec_count: count=%h expected 2 after 12 steps", model); end
    tests++;
    if (step_q.size() != 0) begin fails++; $display("FAIL mode_drain: %0d steps missing, expected 0", step_q.size()); end
  endtask

  task automatic test_dir();
    do_reset();
    btn_pause = 1'b1;
    btn_dir   = 1'b1;
    push_steps(15, 31);
    run_to(7);
    tests++;
    if ({mode, incr, running} !== 3'b101) begin
      fails++;
      $display("FAIL dir_toggle: mode,incr,running=%b expected 101", {mode, incr, running});
    end
    run_to(10);
    btn_pause = 1'b0;
    btn_dir   = 1'b0;
    run_to(16);
    tests++;
    if (model !== 4'hF) begin fails++; $display("FAIL hex_down_wrap: count=%h expected f", model); end
    run_to(32);
    tests++;
    if (model !== 4'hD) begin fails++; $display("FAIL hex_down: count=%h expected d", model); end
    tests++;
    if (step_q.size() != 0) begin fails++; $display("FAIL dir_drain: %0d steps missing, expected 0", step_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    btn_mode  = 1'b1;
    btn_dir   = 1'b1;
    btn_pause = 1'b1;
    push_steps(15, 15);
    run_to(7);
    tests++;
    if ({mode, incr, running} !== 3'b001) begin
      fails++;
      $display("FAIL simul_toggle: mode,incr,running=%b expected 001", {mode, incr, running});
    end
    run_to(10);
    btn_mode = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0;
    run_to(20);
    tests++;
    if (model !== 4'd9) begin fails++; $display("FAIL dec_down_wrap: count=%h expected 9", model); end
    tests++;
    if (step_q.size() != 0) begin fails++; $display("FAIL simul_drain: %0d steps missing, expected 0", step_q.size()); end
  endtask

  task automatic test_clear_on_step();
    do_reset();
    btn_pause = 1'b1;
    push_steps(15, 23);
    run_to(10);
    btn_pause = 1'b0;
    run_to(24);
    btn_clear = 1'b1;
    push_steps(39, 47);
    run_to(30);
    btn_clear = 1'b0;
    tests++;
    if (clear !== 1'b0) begin fails++; $display("FAIL clear_early: clear=%b expected 0 at edge 30", clear); end
    run_to(31);
    tests++;
    if (clear !== 1'b1 || pause !== 1'b1) begin
      fails++;
      $display("FAIL clear_pulse: clear=%b pause=%b expected clear=1 pause=1", clear, pause);
    end
    run_to(32);
    tests++;
    if (clear !== 1'b0 || model !== 4'd0 || running !== 1'b1) begin
      fails++;
      $display("FAIL clear_after: clear=%b count=%h running=%b expected 0,0,1", clear, model, running);
    end
    run_to(48);
    tests++;
    if (model !== 4'd2) begin fails++; $display("FAIL clear_resume: count=%h expected 2", model); end
    tests++;
    if (step_q.size() != 0) begin fails++; $display("FAIL clear_drain: %0d steps missing, expected 0", step_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    btn_pause = 1'b1;
    push_steps(15, 15);
    run_to(10);
    btn_pause = 1'b0;
    run_to(18);
    btn_mode = 1'b1;
    btn_dir  = 1'b1;
    run_to(20);
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL pre_reset: running=%b expected 1", running); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({clear, mode, incr, pause, running} !== 5'b01110) begin
      fails++;
      $display("FAIL async_reset: outputs=%b expected=01110", {clear, mode, incr, pause, running});
    end
    tests++;
    if (step_q.size() != 0) begin fails++; $display("FAIL async_drain: %0d steps missing, expected 0", step_q.size()); end
    btn_mode = 1'b0;
    btn_dir  = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      tick();
      tests++;
      if ({clear, mode, incr, running} !== 4'b0110) begin
        fails++;
        $display("FAIL post_reset edge %0d: clear,mode,incr,running=%b expected 0110", edge_no, {clear, mode, incr, running});
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_mode_glitch();
    test_dir();
    test_back_to_back();
    test_clear_on_step();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
